// File: rtl/edge_detect.sv
// -----------------------------------------------------------------------------
// edge_detect
//   Sobel edge stage that sits directly after the intensity stage. When the
//   controller pulses edgedetect_enable, the module captures one 3x3 greyscale
//   window. It computes |Gx|+|Gy| and compares that sum with THRESHOLD. It then
//   emits one registered edge bit per window. The cartoon compositor uses this
//   bit to draw the black outline.
//
//   The module takes three clocks per window:
//     capture -> GRAD (register Gx/Gy) -> MAG (register result) -> DONE.
//   While the module is in DONE, a new enable starts the next window
//   back-to-back.
//
// Optional feature macro: EDGE_MAG_OUT_EN
//   When the macro is defined, the module adds the saturated 8-bit magnitude
//   output and its register. When the macro is undefined, neither the port nor
//   the register exists. Timing and edge_pixel behaviour are the same in both
//   builds.
//
// Ports
//   clk                in   1   system clock, rising edge
//   n_rst              in   1   asynchronous active-low reset
//   edgedetect_enable  in   1   start request, sampled only in IDLE or DONE
//   iGrid              in   72  I0=[71:64] .. I8=[7:0], row-major, I4 centre
//   edge_pixel         out  1   registered result, 1 = edge
//   edge_done          out  1   high for one cycle when a new result is valid
//   edge_busy          out  1   high in GRAD and MAG
//   magnitude          out  8   (EDGE_MAG_OUT_EN only) saturated |Gx|+|Gy|
// -----------------------------------------------------------------------------
module edge_detect #(
  parameter logic [10:0] THRESHOLD = 11'd128
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        edgedetect_enable,
  input  logic [71:0] iGrid,
`ifdef EDGE_MAG_OUT_EN
  output logic [7:0]  magnitude,
`endif
  output logic        edge_pixel,
  output logic        edge_done,
  output logic        edge_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GRAD = 2'd1,
    MAG  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               load_win;
  logic [71:0]        win_q;
  logic signed [10:0] gx_q, gy_q, gx_d, gy_d;
  logic [10:0]        sum;
  logic               edge_pixel_q;
`ifdef EDGE_MAG_OUT_EN
  logic [7:0]         mag_q;
`endif

  // Zero-extends one 8-bit pixel into the 11-bit signed gradient domain.
  function automatic logic signed [10:0] px(input logic [7:0] p);
    return $signed({3'b000, p});
  endfunction

  // Returns the full-range absolute value. The result magnitude never exceeds
  // 1020, so 11 bits hold it exactly and nothing is truncated.
  function automatic logic [10:0] abs11(input logic signed [10:0] x);
    return x[10] ? $unsigned(-x) : $unsigned(x);
  endfunction

  // Clamps the 11-bit sum to the 8-bit magnitude output.
  function automatic logic [7:0] sat8(input logic [10:0] s);
    return (s > 11'd255) ? 8'hFF : s[7:0];
  endfunction

  logic [7:0] i0, i1, i2, i3, i5, i6, i7, i8;
  assign {i0, i1, i2, i3} = win_q[71:40];
  assign {i5, i6, i7, i8} = win_q[31:0];

  // Both Sobel kernels give the centre pixel zero weight, so it is never read.
  logic centre_unused;
  assign centre_unused = ^win_q[39:32];

  // Next-state logic. The enable input is honoured only where a capture is
  // allowed. While the module is busy, it drops the enable instead of
  // queuing it.
  always_comb begin
    state_d  = state_q;
    load_win = 1'b0;
    case (state_q)
      IDLE: begin
        if (edgedetect_enable) begin
          load_win = 1'b1;
          state_d  = GRAD;
        end
      end
      GRAD: state_d = MAG;
      MAG:  state_d = DONE;
      DONE: begin
        if (edgedetect_enable) begin
          load_win = 1'b1;
          state_d  = GRAD;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Gradient stage. Each partial sum is at most 1020, so the 11-bit signed
  // width covers both the sums and their difference.
  always_comb begin
    gx_d = (px(i2) + (px(i5) <<< 1) + px(i8)) - (px(i0) + (px(i3) <<< 1) + px(i6));
    gy_d = (px(i6) + (px(i7) <<< 1) + px(i8)) - (px(i0) + (px(i1) <<< 1) + px(i2));
  end

  // Magnitude stage. The sum is at most 2040, so it fits in 11 bits unsigned.
  assign sum = abs11(gx_q) + abs11(gy_q);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      win_q        <= '0;
      gx_q         <= '0;
      gy_q         <= '0;
      edge_pixel_q <= 1'b0;
`ifdef EDGE_MAG_OUT_EN
      mag_q        <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (load_win) begin
        win_q <= iGrid;
      end
      if (state_q == GRAD) begin
        gx_q <= gx_d;
        gy_q <= gy_d;
      end
      // Results hold their value until the next MAG cycle.
      if (state_q == MAG) begin
        edge_pixel_q <= (sum > THRESHOLD);
`ifdef EDGE_MAG_OUT_EN
        mag_q        <= sat8(sum);
`endif
      end
    end
  end

  assign edge_pixel = edge_pixel_q;
  assign edge_done  = (state_q == DONE);
  assign edge_busy  = (state_q == GRAD) || (state_q == MAG);
`ifdef EDGE_MAG_OUT_EN
  assign magnitude  = mag_q;
`endif

endmodule

// File: tb/tb_edge_detect.sv
// -----------------------------------------------------------------------------
// tb_edge_detect
//   Directed bench for edge_detect. Each step drives one window, walks through
//   the FSM cycle by cycle on falling edges, and compares the outputs with
//   hand-computed values. The magnitude port is checked only when
//   EDGE_MAG_OUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_edge_detect;

  logic        clk;
  logic        n_rst;
  logic        edgedetect_enable;
  logic [71:0] iGrid;
  logic        edge_pixel;
  logic        edge_done;
  logic        edge_busy;
  logic [7:0]  magnitude;

  int checks;
  int failures;
  int done_cnt;

  edge_detect dut (
    .clk               (clk),
    .n_rst             (n_rst),
    .edgedetect_enable (edgedetect_enable),
    .iGrid             (iGrid),
`ifdef EDGE_MAG_OUT_EN
    .magnitude         (magnitude),
`endif
    .edge_pixel        (edge_pixel),
    .edge_done         (edge_done),
    .edge_busy         (edge_busy)
  );

`ifndef EDGE_MAG_OUT_EN
  assign magnitude = 8'd0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] grid(input logic [7:0] p0, p1, p2, p3, p4,
                                       p5, p6, p7, p8);
    return {p0, p1, p2, p3, p4, p5, p6, p7, p8};
  endfunction

  // Starts a window from IDLE and checks every cycle up to the return to IDLE.
  task automatic run_window(input logic [71:0] g, input logic exp_pix,
                            input logic [7:0] exp_mag, input string tag);
    @(negedge clk);
    iGrid = g;
    edgedetect_enable = 1'b1;
    @(negedge clk);                       // GRAD
    edgedetect_enable = 1'b0;
    check({tag, ".grad_busy"}, edge_busy, 1);
    check({tag, ".grad_done"}, edge_done, 0);
    @(negedge clk);                       // MAG
    check({tag, ".mag_busy"}, edge_busy, 1);
    check({tag, ".mag_done"}, edge_done, 0);
    @(negedge clk);                       // DONE
    check({tag, ".done"}, edge_done, 1);
    check({tag, ".done_busy"}, edge_busy, 0);
    check({tag, ".pix"}, edge_pixel, exp_pix);
`ifdef EDGE_MAG_OUT_EN
    check({tag, ".mag"}, magnitude, exp_mag);
`endif
    @(negedge clk);                       // IDLE, result held
    check({tag, ".idle_done"}, edge_done, 0);
    check({tag, ".hold_pix"}, edge_pixel, exp_pix);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    n_rst = 1'b0;
    edgedetect_enable = 1'b0;
    iGrid = '0;

    // Reset state
    #12;
    check("rst.pix", edge_pixel, 0);
    check("rst.done", edge_done, 0);
    check("rst.busy", edge_busy, 0);
`ifdef EDGE_MAG_OUT_EN
    check("rst.mag", magnitude, 0);
`endif
    @(negedge clk);
    n_rst = 1'b1;

    // Uniform 50: Gx=Gy=0
    run_window(grid(50,50,50,50,50,50,50,50,50), 1'b0, 8'd0, "uniform");
    // Left 0, middle 100, right 200: Gx=800, Gy=0 -> saturated
    run_window(grid(0,100,200,0,100,200,0,100,200), 1'b1, 8'd255, "vedge");
    // Threshold boundary: sum=128 is not an edge, sum=132 is
    run_window(grid(0,0,32,0,0,32,0,0,32), 1'b0, 8'd128, "thr128");
    run_window(grid(0,0,33,0,0,33,0,0,33), 1'b1, 8'd132, "thr132");
    // Top row 200, rest 0: Gy=-800, sum=800
    run_window(grid(200,200,200,0,0,0,0,0,0), 1'b1, 8'd255, "neg_gy");
    // Asymmetric ramps: Gx=8,Gy=24 -> 32 ; Gx=-8,Gy=-24 -> 32
    run_window(grid(1,2,3,4,5,6,7,8,9), 1'b0, 8'd32, "ramp_up");
    run_window(grid(9,8,7,6,5,4,3,2,1), 1'b0, 8'd32, "ramp_dn");
    // Gx=80, Gy=240 -> 320
    run_window(grid(10,20,30,40,50,60,70,80,90), 1'b1, 8'd255, "ramp10");
    // Full negative swing: Gy=-1020, abs must give 1020
    run_window(grid(255,255,255,0,0,0,0,0,0), 1'b1, 8'd255, "abs1020");

    // Enable re-pulsed in GRAD with a different grid is ignored
    @(negedge clk);
    iGrid = grid(50,50,50,50,50,50,50,50,50);
    edgedetect_enable = 1'b1;
    @(negedge clk);                       // GRAD
    iGrid = grid(0,100,200,0,100,200,0,100,200);
    edgedetect_enable = 1'b1;
    @(negedge clk);                       // MAG
    edgedetect_enable = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      if (edge_done) done_cnt++;
      if (i == 1) check("busy.pix", edge_pixel, 0);
      @(negedge clk);
    end
    check("busy.done_count", done_cnt, 1);

    // Enable held high: edge_done every third clock
    iGrid = grid(0,100,200,0,100,200,0,100,200);
    edgedetect_enable = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      check($sformatf("b2b.done%0d", i), edge_done, (i % 3 == 0));
      check($sformatf("b2b.busy%0d", i), edge_busy, (i % 3 != 0));
    end
    edgedetect_enable = 1'b0;
    check("b2b.pix", edge_pixel, 1);
    @(negedge clk);
    check("b2b.idle", edge_done, 0);

    // Async reset while in MAG, with a window that would clear edge_pixel
    iGrid = grid(50,50,50,50,50,50,50,50,50);
    edgedetect_enable = 1'b1;
    @(negedge clk);                       // GRAD
    edgedetect_enable = 1'b0;
    @(negedge clk);                       // MAG
    check("abort.in_mag", edge_busy, 1);
    #2 n_rst = 1'b0;
    #1;
    check("abort.pix", edge_pixel, 0);
    check("abort.done", edge_done, 0);
    check("abort.busy", edge_busy, 0);
`ifdef EDGE_MAG_OUT_EN
    check("abort.mag", magnitude, 0);
`endif
    @(negedge clk);
    n_rst = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (edge_done) done_cnt++;
    end
    check("abort.no_done", done_cnt, 0);
    // Recovery with a fresh enable
    run_window(grid(0,0,33,0,0,33,0,0,33), 1'b1, 8'd132, "recover");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
